// File: rtl/mips32_pkg.sv
// Shared types and defaults for the mips32 instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips32_pkg;

  localparam int                         DEFAULT_WORD_W   = 32;
  localparam logic [DEFAULT_WORD_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  // One decoded-side fetch slot: the instruction word and the address after it.
  typedef struct packed {
    logic [DEFAULT_WORD_W-1:0] ir;
    logic [DEFAULT_WORD_W-1:0] npc;
  } fetch_entry_t;

  // RUN: every response is on the current path. FLUSH: stale responses still in flight.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mips32_fetch_queue.sv
// In-order instruction queue holding fetch_entry_t slots between memory and decode.
// Latency: a pushed entry is visible at the head one cycle after the push edge (no bypass).
// Backpressure: push into a full queue is ignored unless a pop frees the slot the same cycle.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; a flush discards every entry at once.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until the first fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/mips32_fetch_unit.sv
// Fetch front end: owns the PC, issues word fetches, queues IR/NPC pairs for decode, applies redirects.
// Latency: request to if_valid is 2 cycles minimum; a response shows on if_valid the cycle after it arrives.
// Backpressure: id_stall holds the head; requests stop once queued + in-flight reaches DEPTH.
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [31:0]       RESET_PC = DEFAULT_RESET_PC,
  // The queue entry layout is fixed to the package width, so this must stay at its default.
  parameter int                WORD_W   = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_ir,
  output logic [WORD_W-1:0] if_npc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  fetch_state_e      state_q, state_d;

  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    used_slots;
  fetch_entry_t      q_head;
  fetch_entry_t      q_push_dat;
  logic              q_push;
  logic              q_pop;
  logic              q_empty;
  logic              q_full;
  logic              req_hs;

  // Every slot is either queued or reserved by an in-flight request, so a kept response always fits.
  assign used_slots = (CNT_W+1)'(q_count) + (CNT_W+1)'(outst_q);

  assign imem_req  = !rst && !br_taken && (used_slots < (CNT_W+1)'(DEPTH));
  assign imem_addr = pc_q;
  assign req_hs    = imem_req && imem_ready;

  // Responses are kept only on the current path; a redirect cycle's response is always stale.
  assign q_push           = imem_rvalid && !br_taken && (state_q == ST_RUN);
  assign q_push_dat.ir    = imem_rdata;
  assign q_push_dat.npc   = resp_pc_q + WORD_W'(1);

  assign if_valid = !q_empty && !br_taken;
  assign q_pop    = if_valid && !id_stall;
  assign if_ir    = q_head.ir;
  assign if_npc   = q_head.npc;

  mips32_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (q_push),
    .push_dat_i (q_push_dat),
    .pop_i      (q_pop),
    .flush_i    (br_taken),
    .count_o    (q_count),
    .head_o     (q_head),
    .empty_o    (q_empty),
    .full_o     (q_full)
  );

  // PC, credit, drop-count and RUN/FLUSH next-state; redirect overrides normal advance.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    state_d   = state_q;

    if (req_hs)      outst_d = outst_d + CNT_W'(1);
    if (imem_rvalid) outst_d = outst_d - CNT_W'(1);

    if (br_taken) begin
      pc_d      = br_target;
      resp_pc_d = br_target;
      // Everything still in flight after this cycle is wrong-path, including requests
      // already marked stale by an earlier redirect, so the drop count is the full total.
      drop_d    = outst_q - CNT_W'(imem_rvalid);
    end else begin
      if (req_hs) pc_d = pc_q + WORD_W'(1);
      if (imem_rvalid) begin
        if (state_q == ST_FLUSH) drop_d    = drop_q - CNT_W'(1);
        else                     resp_pc_d = resp_pc_q + WORD_W'(1);
      end
    end

    case (state_q)
      ST_RUN:   if (drop_d != '0) state_d = ST_FLUSH;
      ST_FLUSH: if (drop_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State registers; reset abandons all in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      state_q   <= ST_RUN;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
    end
  end

  // A kept response must never meet a full queue that is not draining this cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !q_pop));

  // Memory must never answer more requests than were accepted.
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_mips32_fetch_unit.sv
`timescale 1ns/1ps
module tb_mips32_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready  = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        br_taken    = 1'b0;
  logic [31:0] br_target   = '0;
  logic        id_stall    = 1'b0;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;

  always #5 clk = ~clk;

  mips32_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] ir; logic [31:0] npc; } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          ready_rand = 0;
  bit          stall_rand = 0;
  int          hs_cnt = 0;
  int          n_deliv = 0;
  logic [31:0] req_pc_m = RST_PC;
  pend_t       pend[$];
  exp_t        exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Code memory contents: any fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected delivery stream: contiguous words starting at the current path's first address.
  task automatic load_exp(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      a = start + 32'(i);
      exp_q.push_back('{mem_word(a), a + 32'd1});
    end
  endtask

  // Advance one cycle and drive memory handshake signals just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    br_taken   = 1'b0;
    imem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_rand) id_stall = ($urandom_range(0, 3) == 0);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    br_taken  = 1'b1;
    br_target = t;
    req_pc_m  = t;
    load_exp(t);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_ir"},    if_ir,         32'd0);
    chk({tag, "_if_npc"},   if_npc,        32'd0);
    pend.delete();
    last_due    = 0;
    hs_cnt      = 0;
    req_pc_m    = RST_PC;
    load_exp(RST_PC);
    br_taken    = 1'b0;
    imem_rvalid = 1'b0;
    id_stall    = 1'b0;
    stall_rand  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    imem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Monitor: memory acceptance, request rules, and the scoreboard on delivered instructions.
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;
  bit          prev_hold = 0;
  logic [31:0] prev_ir = '0;
  logic [31:0] prev_npc = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    int   d;
    if (rst) begin
      prev_wait = 0;
      prev_hold = 0;
    end else begin
      if (br_taken) begin
        chk("no_req_in_redirect",   32'(imem_req), 32'd0);
        chk("no_valid_in_redirect", 32'(if_valid), 32'd0);
      end
      if (prev_wait && !br_taken) begin
        chk("req_held",      32'(imem_req), 32'd1);
        chk("req_addr_held", imem_addr,     prev_addr);
      end
      if (prev_hold && !br_taken) begin
        chk("stall_valid_held", 32'(if_valid), 32'd1);
        chk("stall_ir_held",    if_ir,         prev_ir);
        chk("stall_npc_held",   if_npc,        prev_npc);
      end
      if (imem_req && imem_ready) begin
        chk("imem_addr", imem_addr, req_pc_m);
        req_pc_m = req_pc_m + 32'd1;
        hs_cnt++;
        d = cyc + $urandom_range(lat_min, lat_max);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{imem_addr, d});
      end
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got ir %h npc %h expected nothing (cycle %0d)", if_ir, if_npc, cyc);
        end else if (!id_stall) begin
          e = exp_q.pop_front();
          chk("if_ir",  if_ir,  e.ir);
          chk("if_npc", if_npc, e.npc);
          n_deliv++;
        end else begin
          chk("head_ir_peek", if_ir, exp_q[0].ir);
        end
      end
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
      prev_hold = if_valid && id_stall;
      prev_ir   = if_ir;
      prev_npc  = if_npc;
    end
  end

  initial begin : stim
    int guard;

    // Reset state and zero-wait streaming: first if_valid two cycles after release.
    #1;
    do_reset("reset");
    lat_min = 1; lat_max = 1; ready_rand = 0;
    @(negedge clk); chk("first_valid_c0", 32'(if_valid), 32'd0);
    step(); @(negedge clk); chk("first_valid_c1", 32'(if_valid), 32'd0);
    step(); @(negedge clk); chk("first_valid_c2", 32'(if_valid), 32'd1);
    chk("first_ir", if_ir, mem_word(RST_PC));
    chk("first_npc", if_npc, RST_PC + 32'd1);
    repeat (30) step();

    // Stall from release: exactly DEPTH fetches, then requests stop with the head held.
    do_reset("reset2");
    id_stall = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("stall_hs_count", 32'(hs_cnt), 32'(DEPTH));
    chk("stall_req_off",  32'(imem_req), 32'd0);
    chk("stall_head_ir",  if_ir, mem_word(RST_PC));
    step(); id_stall = 1'b0;
    repeat (40) step();

    // Redirect to 0x14 with several requests still in flight.
    lat_min = 4; lat_max = 4;
    do_reset("reset3");
    guard = 0;
    step();
    while (pend.size() < 3 && guard < 50) begin step(); guard++; end
    chk("wait_three_outstanding", 32'(pend.size() >= 3), 32'd1);
    redirect(32'h14);
    guard = 0;
    step();
    @(negedge clk);
    while (!if_valid && guard < 50) begin step(); @(negedge clk); guard++; end
    chk("redir_ir",  if_ir,  mem_word(32'h14));
    chk("redir_npc", if_npc, 32'h15);
    repeat (20) step();

    // Redirect in the same cycle as a response while the stalled queue is filling.
    lat_min = 2; lat_max = 2;
    do_reset("reset4");
    id_stall = 1'b1;
    guard = 0;
    step();
    while (!(imem_rvalid && if_valid && pend.size() >= 1) && guard < 50) begin step(); guard++; end
    chk("wait_coincident", 32'(imem_rvalid && if_valid), 32'd1);
    redirect(32'h40);
    repeat (6) step();
    id_stall = 1'b0;
    repeat (30) step();

    // Two redirects two cycles apart under random latency, readiness and stalls.
    lat_min = 1; lat_max = 5; ready_rand = 1;
    do_reset("reset5");
    stall_rand = 1;
    repeat (10) step();
    step(); redirect(32'h08);
    step();
    step(); redirect(32'h1C);
    repeat (80) step();

    // Address wrap at the top of the address space.
    lat_min = 1; lat_max = 1; ready_rand = 0; stall_rand = 0; id_stall = 1'b0;
    step(); redirect(32'hFFFF_FFFD);
    repeat (25) step();

    // Long random run with sporadic redirects, some near the wrap point.
    lat_min = 1; lat_max = 5; ready_rand = 1; stall_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0) redirect(32'hFFFF_FFF0 | ($urandom & 32'hF));
        else                           redirect($urandom & 32'h3FF);
      end
    end

    // Asynchronous reset in the middle of traffic, then restart from RESET_PC.
    step();
    #2;
    ready_rand = 0; lat_min = 1; lat_max = 1;
    do_reset("reset_mid");
    repeat (40) step();

    chk("deliveries_seen", 32'(n_deliv > 200), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
